multicycle_sequencer: RTL

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

---
 rtl/multicycle_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//
// Control sequencer for a non-pipelined RV32-style core. It steps each
// instruction through FETCH, DECODE, EXEC and then, depending on the
// instruction, MEM and/or WB. It raises the datapath strobes for each step
// and counts retired instructions.
//
// state | meaning
// ------+-------------------------------------------------------------
//   0   | FETCH  : request instruction, load IR when imem_ready
//   1   | DECODE : capture opcode, check legality
//   2   | EXEC   : ALU / branch compare; B retires here
//   3   | MEM    : data access, hold until dmem_ready; SW retires here
//   4   | WB     : register write, instruction retires
//   5   | HALT   : illegal opcode seen, terminal until rst
//  6-7  | unused : recover to FETCH on the next edge
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-high reset
//   opcode       in   instruction[6:0] from the instruction register
//   branch_taken in   branch comparator result (used in EXEC only)
//   imem_ready   in   instruction memory data valid (used in FETCH only)
//   dmem_ready   in   data memory access complete (used in MEM only)
//   imem_req     out  instruction fetch request
//   ir_we        out  instruction register load strobe
//   dmem_req     out  data memory access request
//   dmem_we      out  data memory write qualifier (valid with dmem_req)
//   reg_we       out  register file write strobe
//   pc_we        out  PC update strobe, one pulse per instruction
//   pc_sel       out  1 = jump/branch target, 0 = PC+4
//   illegal      out  sticky illegal-opcode flag
//   state        out  current state code
//   instret      out  retired-instruction counter (wraps silently)

module multicycle_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  state_t      state_q;
  state_t      state_d;
  logic [6:0]  op_q;
  logic        illegal_q;
  logic [31:0] instret_q;

  logic        opcode_legal;
  logic        op_is_lw;
  logic        op_is_sw;
  logic        op_is_b;
  logic        op_is_jump;
  logic        retire;

  always_comb begin
    opcode_legal = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LW, OP_SW, OP_B, OP_JALR, OP_JAL, OP_LUI: opcode_legal = 1'b1;
      default:                                                 opcode_legal = 1'b0;
    endcase
  end

  assign op_is_lw   = (op_q == OP_LW);
  assign op_is_sw   = (op_q == OP_SW);
  assign op_is_b    = (op_q == OP_B);
  assign op_is_jump = (op_q == OP_JAL) || (op_q == OP_JALR);

  // Next-state logic.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = imem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_d = opcode_legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (op_is_lw || op_is_sw) state_d = S_MEM;
        else if (op_is_b)         state_d = S_FETCH;
        else                      state_d = S_WB;
      end
      S_MEM: begin
        if (!dmem_ready)   state_d = S_MEM;
        else if (op_is_sw) state_d = S_FETCH;
        else               state_d = S_WB;
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Retire happens on the edge that leaves the retiring state. A store has
  // no WB step, so its retire is the MEM cycle that sees dmem_ready; that
  // is the one place the retire depends on an input, in the same way that
  // ir_we depends on imem_ready.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_EXEC:  retire = op_is_b;
      S_MEM:   retire = op_is_sw && dmem_ready;
      S_WB:    retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  // Output decode. Everything is forced low while rst is high so that the
  // FETCH reset state does not present a fetch request during reset.
  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    reg_we   = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ready;
        end
        S_EXEC: begin
          pc_we  = retire;
          // The comparator result seen in EXEC is the one the PC update
          // on this edge uses.
          pc_sel = retire && branch_taken;
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = op_is_sw;
          pc_we    = retire;
        end
        S_WB: begin
          reg_we = 1'b1;
          pc_we  = 1'b1;
          pc_sel = op_is_jump;
        end
        default: begin
          imem_req = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= 7'd0;
      illegal_q <= 1'b0;
      instret_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
        if (!opcode_legal) illegal_q <= 1'b1;
      end
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  assign illegal = illegal_q;
  assign state   = state_q;
  assign instret = instret_q;

endmodule
